// File: rtl/drive_state_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drive_state_ctrl_pkg
//  Description : Shared definitions for the driving-mode controller.
//                Holds the one-hot driving-state encodings, the default
//                mileage record width and a small state helper. The
//                downstream LED/display controller uses the same encodings.
//  Contents    : drive_state_t - one-hot driving state
//                c_rec_w       - default mileage record width
//                is_moving()   - true for either moving state
//  Revision    : 1.0 - initial release
// ============================================================================
package drive_state_ctrl_pkg;

  localparam int c_rec_w = 27;

  typedef enum logic [3:0] {
    ST_NOT_STARTING = 4'b1000,
    ST_STARTING     = 4'b0100,
    ST_MOVING_FWD   = 4'b0010,
    ST_MOVING_REV   = 4'b0001
  } drive_state_t;

  function automatic logic is_moving(input drive_state_t s);
    return (s == ST_MOVING_FWD) || (s == ST_MOVING_REV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/drive_state_ctrl_mileage_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mileage_counter
//  Description : Rising-edge detect on the mileage pacing signal and a
//                saturating distance counter.
//  Ports       : clk      - system clock
//                rst      - asynchronous active-high reset
//                count_en - vehicle is moving; ticks are counted only then
//                clear    - synchronous clear of the record (power off)
//                clk_bps  - pacing signal, each rise is one distance unit
//                record   - mileage count, saturates at REC_MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module mileage_counter
  import drive_state_ctrl_pkg::*;
#(
  parameter int               REC_W   = c_rec_w,
  parameter logic [REC_W-1:0] REC_MAX = {REC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clear,
  input  logic             clk_bps,
  output logic [REC_W-1:0] record
);

  logic r_clk_bps_d;
  logic w_bps_tick;

  assign w_bps_tick = clk_bps & ~r_clk_bps_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_bps_d <= 1'b0;
      record      <= '0;
    end else begin
      r_clk_bps_d <= clk_bps;
      if (clear) begin
        record <= '0;
      end else if (count_en && w_bps_tick && (record != REC_MAX)) begin
        // Hold at REC_MAX rather than wrapping back to zero.
        record <= record + REC_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/drive_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : drive_state_ctrl
//  Description : Driving-mode controller. Turns debounced driver controls
//                into a one-hot driving state, a one-cycle stall pulse and
//                a saturating mileage record.
//  Ports       : clk          - system clock
//                rst          - asynchronous active-high reset
//                power_now    - power switch level, 1 = on
//                clk_bps      - mileage pacing signal
//                throttle     - throttle held
//                clutch       - clutch held
//                brake        - brake held
//                reverse_gear - reverse gear selected
//                state1       - one-hot driving state (registered)
//                record       - mileage count (registered)
//                stall        - one-cycle engine-stall pulse (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module drive_state_ctrl
  import drive_state_ctrl_pkg::*;
#(
  parameter int               REC_W   = c_rec_w,
  parameter logic [REC_W-1:0] REC_MAX = {REC_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_now,
  input  logic             clk_bps,
  input  logic             throttle,
  input  logic             clutch,
  input  logic             brake,
  input  logic             reverse_gear,
  output logic [3:0]       state1,
  output logic [REC_W-1:0] record,
  output logic             stall
);

  drive_state_t r_state;

  assign state1 = r_state;

  // Power-off has top priority: any state falls to NOT_STARTING and no
  // stall is flagged, even if a stall condition is present in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_NOT_STARTING;
      stall   <= 1'b0;
    end else begin
      stall <= 1'b0;
      if (!power_now) begin
        r_state <= ST_NOT_STARTING;
      end else begin
        case (r_state)
          ST_NOT_STARTING: begin
            if (throttle && clutch) begin
              r_state <= ST_STARTING;
            end else if (throttle) begin
              stall <= 1'b1;
            end
          end
          ST_STARTING: begin
            if (throttle && !clutch && !brake) begin
              r_state <= reverse_gear ? ST_MOVING_REV : ST_MOVING_FWD;
            end
          end
          ST_MOVING_FWD: begin
            if (reverse_gear && !clutch) begin
              r_state <= ST_NOT_STARTING;
              stall   <= 1'b1;
            end else if (brake || clutch || !throttle) begin
              r_state <= ST_STARTING;
            end
          end
          ST_MOVING_REV: begin
            if (!reverse_gear && !clutch) begin
              r_state <= ST_NOT_STARTING;
              stall   <= 1'b1;
            end else if (brake || clutch || !throttle) begin
              r_state <= ST_STARTING;
            end
          end
          default: r_state <= ST_NOT_STARTING;
        endcase
      end
    end
  end

  // The counter looks at the current (pre-update) state, so a tick arriving
  // on the edge that enters a moving state is not counted.
  mileage_counter #(
    .REC_W   (REC_W),
    .REC_MAX (REC_MAX)
  ) u_mileage_counter (
    .clk      (clk),
    .rst      (rst),
    .count_en (is_moving(r_state)),
    .clear    (!power_now),
    .clk_bps  (clk_bps),
    .record   (record)
  );

endmodule
`default_nettype wire

// File: tb/tb_drive_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_drive_state_ctrl
//  Description : Directed self-checking bench for drive_state_ctrl. The
//                record width is reduced to 8 bits so saturation is reached
//                with a short tick sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_state_ctrl;

  localparam int               c_w   = 8;
  localparam logic [c_w-1:0]   c_max = 8'hFF;
  localparam logic [3:0] c_ns  = 4'b1000;
  localparam logic [3:0] c_st  = 4'b0100;
  localparam logic [3:0] c_fwd = 4'b0010;
  localparam logic [3:0] c_rev = 4'b0001;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           power_now = 1'b0;
  logic           clk_bps = 1'b0;
  logic           throttle = 1'b0;
  logic           clutch = 1'b0;
  logic           brake = 1'b0;
  logic           reverse_gear = 1'b0;
  logic [3:0]     state1;
  logic [c_w-1:0] record;
  logic           stall;

  int errors = 0;
  int checks = 0;

  logic [3:0]     q_st[$];
  logic [c_w-1:0] q_rec[$];
  logic           q_stall[$];
  string          q_tag[$];

  drive_state_ctrl #(.REC_W(c_w), .REC_MAX(c_max)) dut (
    .clk          (clk),
    .rst          (rst),
    .power_now    (power_now),
    .clk_bps      (clk_bps),
    .throttle     (throttle),
    .clutch       (clutch),
    .brake        (brake),
    .reverse_gear (reverse_gear),
    .state1       (state1),
    .record       (record),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic check_now(input string tag, input logic [3:0] st,
                           input logic [c_w-1:0] rec, input logic stl);
    checks++;
    assert (state1 === st) else begin
      errors++;
      $error("FAIL %s state1 observed=%b expected=%b", tag, state1, st);
    end
    checks++;
    assert (record === rec) else begin
      errors++;
      $error("FAIL %s record observed=%0d expected=%0d", tag, record, rec);
    end
    checks++;
    assert (stall === stl) else begin
      errors++;
      $error("FAIL %s stall observed=%b expected=%b", tag, stall, stl);
    end
  endtask

  // Inputs are already applied; push the expectation for the next edge,
  // then pop and compare once the DUT has produced it.
  task automatic step(input string tag, input logic [3:0] st,
                      input logic [c_w-1:0] rec, input logic stl);
    q_tag.push_back(tag);
    q_st.push_back(st);
    q_rec.push_back(rec);
    q_stall.push_back(stl);
    @(posedge clk);
    #1;
    check_now(q_tag.pop_front(), q_st.pop_front(), q_rec.pop_front(),
              q_stall.pop_front());
  endtask

  initial begin
    int exp_rec;

    // Reset state
    @(posedge clk);
    #1;
    check_now("reset", c_ns, 0, 1'b0);
    rst = 1'b0;

    // Idle with power on
    power_now = 1'b1;
    for (int i = 0; i < 20; i++) step("idle", c_ns, 0, 1'b0);

    // Throttle without clutch from NOT_STARTING stalls
    throttle = 1'b1;
    step("ns_stall", c_ns, 0, 1'b1);
    throttle = 1'b0;
    step("ns_stall_end", c_ns, 0, 1'b0);

    // Start forward
    throttle = 1'b1; clutch = 1'b1;
    step("to_starting", c_st, 0, 1'b0);
    clutch = 1'b0;
    step("to_fwd", c_fwd, 0, 1'b0);

    // 100 distance units forward
    for (int i = 1; i <= 100; i++) begin
      clk_bps = 1'b1;
      step("fwd_rise", c_fwd, c_w'(i), 1'b0);
      clk_bps = 1'b0;
      step("fwd_low", c_fwd, c_w'(i), 1'b0);
    end

    // Wrong direction without clutch: stall, record holds
    reverse_gear = 1'b1;
    step("dir_stall", c_ns, 100, 1'b1);
    throttle = 1'b0;
    step("dir_stall_end", c_ns, 100, 1'b0);

    // Start reverse; a tick on the entry edge is ignored
    throttle = 1'b1; clutch = 1'b1;
    step("rev_starting", c_st, 100, 1'b0);
    clutch = 1'b0; clk_bps = 1'b1;
    step("rev_entry_tick", c_rev, 100, 1'b0);
    clk_bps = 1'b0;
    step("rev_low", c_rev, 100, 1'b0);
    clk_bps = 1'b1;
    step("rev_tick", c_rev, 101, 1'b0);
    clk_bps = 1'b0;
    step("rev_tick_low", c_rev, 101, 1'b0);

    // Power-off and stall condition together: power-off wins, no stall
    reverse_gear = 1'b0; power_now = 1'b0;
    step("poweroff_vs_stall", c_ns, 0, 1'b0);

    // Reverse to 50, brake, ticks ignored in STARTING, then power off
    power_now = 1'b1; reverse_gear = 1'b1; clutch = 1'b1;
    step("rev2_starting", c_st, 0, 1'b0);
    clutch = 1'b0;
    step("rev2_moving", c_rev, 0, 1'b0);
    for (int i = 1; i <= 50; i++) begin
      clk_bps = 1'b1;
      step("rev2_rise", c_rev, c_w'(i), 1'b0);
      clk_bps = 1'b0;
      step("rev2_low", c_rev, c_w'(i), 1'b0);
    end
    brake = 1'b1;
    step("brake", c_st, 50, 1'b0);
    for (int i = 0; i < 10; i++) begin
      clk_bps = 1'b1;
      step("brake_rise", c_st, 50, 1'b0);
      clk_bps = 1'b0;
      step("brake_low", c_st, 50, 1'b0);
    end
    brake = 1'b0; power_now = 1'b0;
    step("power_off", c_ns, 0, 1'b0);

    // Saturation: count past REC_MAX forward
    power_now = 1'b1; reverse_gear = 1'b0; clutch = 1'b1;
    step("sat_starting", c_st, 0, 1'b0);
    clutch = 1'b0;
    step("sat_fwd", c_fwd, 0, 1'b0);
    for (int i = 1; i <= 258; i++) begin
      exp_rec = (i > 255) ? 255 : i;
      clk_bps = 1'b1;
      step("sat_rise", c_fwd, c_w'(exp_rec), 1'b0);
      clk_bps = 1'b0;
      step("sat_low", c_fwd, c_w'(exp_rec), 1'b0);
    end

    // Throttle release drops to STARTING, then back to moving
    throttle = 1'b0;
    step("release", c_st, c_max, 1'b0);
    throttle = 1'b1;
    step("refwd", c_fwd, c_max, 1'b0);

    // Asynchronous reset mid-moving with clk_bps toggling
    rst = 1'b1;
    #1;
    check_now("async_rst", c_ns, 0, 1'b0);
    throttle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_bps = ~clk_bps;
      @(posedge clk);
      #1;
      check_now("rst_hold", c_ns, 0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk_bps = ~clk_bps;
      step("post_rst", c_ns, 0, 1'b0);
    end

    // Moving again: counting resumes from zero
    clk_bps = 1'b0; throttle = 1'b1; clutch = 1'b1;
    step("post_rst_start", c_st, 0, 1'b0);
    clutch = 1'b0;
    step("post_rst_fwd", c_fwd, 0, 1'b0);
    clk_bps = 1'b1;
    step("post_rst_tick", c_fwd, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
